// File: rtl/exe_stage.sv
// Execute stage of the five-stage MIPS pipeline: ALU, iterative shift-add
// multiplier, branch resolution and the EXE/MEM pipeline register.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Dest_in,
    input  logic [31:0] Reg2_in,
    input  logic [31:0] Val1_in,
    input  logic [31:0] Val2_in,
    input  logic [31:0] PC_in,
    input  logic [1:0]  br_type_in,
    input  logic [3:0]  EXE_CMD_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic        WB_EN_in,
    output logic [31:0] ALU_result,
    output logic [31:0] ST_val,
    output logic [4:0]  Dest,
    output logic        MEM_R_EN,
    output logic        MEM_W_EN,
    output logic        WB_EN,
    output logic        Br_taken,
    output logic [31:0] Br_Addr,
    output logic        Freeze
);

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SLA = 4'b1000;
    localparam logic [3:0] CMD_SLL = 4'b1001;
    localparam logic [3:0] CMD_SRA = 4'b1010;
    localparam logic [3:0] CMD_SRL = 4'b1011;
    localparam logic [3:0] CMD_MUL = 4'b1100;

    localparam logic [1:0] BR_BEZ = 2'b01;
    localparam logic [1:0] BR_BNE = 2'b10;
    localparam logic [1:0] BR_JMP = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [31:0]        acc;
    logic [31:0]        mcand;
    logic [31:0]        mplier;
    logic [4:0]         count;
    logic [31:0]        alu_out;
    logic [31:0]        result;
    logic               br_cond;
    logic               is_mul;
    logic signed [31:0] val1_s;

    assign val1_s = $signed(Val1_in);
    assign is_mul = (EXE_CMD_in == CMD_MUL);

    // Single-cycle ALU; MUL is handled by the iterative unit, so it yields 0 here
    always_comb begin
        alu_out = 32'd0;
        case (EXE_CMD_in)
            CMD_ADD: alu_out = Val1_in + Val2_in;
            CMD_SUB: alu_out = Val1_in - Val2_in;
            CMD_AND: alu_out = Val1_in & Val2_in;
            CMD_OR:  alu_out = Val1_in | Val2_in;
            CMD_NOR: alu_out = ~(Val1_in | Val2_in);
            CMD_XOR: alu_out = Val1_in ^ Val2_in;
            CMD_SLA,
            CMD_SLL: alu_out = Val1_in << Val2_in[4:0];
            CMD_SRA: alu_out = val1_s >>> Val2_in[4:0];
            CMD_SRL: alu_out = Val1_in >> Val2_in[4:0];
            default: alu_out = 32'd0;
        endcase
    end

    // Stall upstream from the detect cycle through the last multiply iteration
    assign Freeze = ((state == IDLE) && is_mul) || (state == BUSY);

    // In DONE the accumulator carries the product; otherwise the ALU result
    assign result = (state == DONE) ? acc : alu_out;

    // Branch condition and target; resolved only in IDLE when not stalling
    always_comb begin
        br_cond = 1'b0;
        case (br_type_in)
            BR_BEZ:  br_cond = (Val1_in == 32'd0);
            BR_BNE:  br_cond = (Val1_in != Reg2_in);
            BR_JMP:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign Br_taken = br_cond && (state == IDLE) && !Freeze;
    assign Br_Addr  = PC_in + (Val2_in << 2);

    // Shift-add multiplier FSM: one detect cycle, 32 iterations, one DONE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            acc    <= 32'd0;
            mcand  <= 32'd0;
            mplier <= 32'd0;
            count  <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        mcand  <= Val1_in;
                        mplier <= Val2_in;
                        acc    <= 32'd0;
                        count  <= 5'd0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // EXE/MEM register: bubble while stalled, data registers hold their value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALU_result <= 32'd0;
            ST_val     <= 32'd0;
            Dest       <= 5'd0;
            MEM_R_EN   <= 1'b0;
            MEM_W_EN   <= 1'b0;
            WB_EN      <= 1'b0;
        end else if (Freeze) begin
            Dest       <= 5'd0;
            MEM_R_EN   <= 1'b0;
            MEM_W_EN   <= 1'b0;
            WB_EN      <= 1'b0;
        end else begin
            ALU_result <= result;
            ST_val     <= Reg2_in;
            Dest       <= Dest_in;
            MEM_R_EN   <= MEM_R_EN_in;
            MEM_W_EN   <= MEM_W_EN_in;
            WB_EN      <= WB_EN_in;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: a driver issues instructions and queues the
// expected EXE/MEM contents; a monitor pops and compares after every edge.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  Dest_in = '0;
    logic [31:0] Reg2_in = '0;
    logic [31:0] Val1_in = '0;
    logic [31:0] Val2_in = '0;
    logic [31:0] PC_in = '0;
    logic [1:0]  br_type_in = '0;
    logic [3:0]  EXE_CMD_in = '0;
    logic        MEM_R_EN_in = 1'b0;
    logic        MEM_W_EN_in = 1'b0;
    logic        WB_EN_in = 1'b0;
    logic [31:0] ALU_result;
    logic [31:0] ST_val;
    logic [4:0]  Dest;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        WB_EN;
    logic        Br_taken;
    logic [31:0] Br_Addr;
    logic        Freeze;

    exe_stage dut (
        .clk(clk), .rst(rst), .Dest_in(Dest_in), .Reg2_in(Reg2_in),
        .Val1_in(Val1_in), .Val2_in(Val2_in), .PC_in(PC_in),
        .br_type_in(br_type_in), .EXE_CMD_in(EXE_CMD_in),
        .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
        .ALU_result(ALU_result), .ST_val(ST_val), .Dest(Dest),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN),
        .Br_taken(Br_taken), .Br_Addr(Br_Addr), .Freeze(Freeze)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] st;
        logic [4:0]  dest;
        logic        mr;
        logic        mw;
        logic        wb;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = '0;
    logic [31:0] last_st = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    // Reference ALU written directly from the operation table
    function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (cmd)
            4'd0:  return a + b;
            4'd2:  return a - b;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return ~(a | b);
            4'd7:  return a ^ b;
            4'd8, 4'd9: return a << sh;
            4'd10: return $unsigned($signed(a) >>> sh);
            4'd11: return a >> sh;
            4'd12: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [1:0] br, input logic [31:0] a, input logic [31:0] r2);
        if (br == 2'd1) return (a == 0);
        if (br == 2'd2) return (a != r2);
        if (br == 2'd3) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: after every edge compare the EXE/MEM outputs to the queue head
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("alu_result", ALU_result, e.res);
            check("st_val", ST_val, e.st);
            check("dest", {27'd0, Dest}, {27'd0, e.dest});
            check("ctrl", {29'd0, MEM_R_EN, MEM_W_EN, WB_EN}, {29'd0, e.mr, e.mw, e.wb});
        end
    end

    task automatic push_bubble();
        exp_t e;
        e.res = last_res; e.st = last_st; e.dest = 5'd0;
        e.mr = 1'b0; e.mw = 1'b0; e.wb = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push_result(input logic [31:0] r);
        exp_t e;
        e.res = r; e.st = Reg2_in; e.dest = Dest_in;
        e.mr = MEM_R_EN_in; e.mw = MEM_W_EN_in; e.wb = WB_EN_in;
        last_res = r; last_st = Reg2_in;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] r2, input logic [31:0] pc, input logic [1:0] br,
                         input logic [4:0] dst, input logic [2:0] ctl);
        EXE_CMD_in = cmd; Val1_in = v1; Val2_in = v2; Reg2_in = r2; PC_in = pc;
        br_type_in = br; Dest_in = dst;
        {MEM_R_EN_in, MEM_W_EN_in, WB_EN_in} = ctl;
    endtask

    // Issue one instruction; a MUL is held stable through its whole stall
    task automatic issue(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] r2, input logic [31:0] pc, input logic [1:0] br,
                         input logic [4:0] dst, input logic [2:0] ctl);
        int fc;
        @(negedge clk);
        drive(cmd, v1, v2, r2, pc, br, dst, ctl);
        #1;
        if (cmd == 4'd12) begin
            fc = 0;
            for (int i = 0; i < 33; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    #1;
                end
                if (Freeze === 1'b1) fc++;
                check("freeze_mul", {31'd0, Freeze}, 32'd1);
                push_bubble();
            end
            check("freeze_len", fc, 33);
            @(negedge clk);
            #1;
            check("freeze_done", {31'd0, Freeze}, 32'd0);
            check("br_taken_done", {31'd0, Br_taken}, 32'd0);
            push_result(ref_alu(cmd, v1, v2));
        end else begin
            check("freeze_alu", {31'd0, Freeze}, 32'd0);
            check("br_taken", {31'd0, Br_taken}, {31'd0, ref_taken(br, v1, r2)});
            check("br_addr", Br_Addr, pc + v2 * 4);
            push_result(ref_alu(cmd, v1, v2));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_res"}, ALU_result, 32'd0);
        check({tag, "_st"}, ST_val, 32'd0);
        check({tag, "_ctl"}, {24'd0, Dest, MEM_R_EN, MEM_W_EN, WB_EN}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  c;
        logic [31:0] a, b, r;

        // Reset held with random inputs
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(4'($urandom_range(0, 11)), $urandom, $urandom, $urandom, $urandom,
                  2'($urandom), 5'($urandom), 3'($urandom));
        end
        drive(4'd0, 0, 0, 0, 0, 2'd0, 5'd0, 3'd0);
        #1;
        check_all_zero("reset");
        check("reset_freeze", {31'd0, Freeze}, 32'd0);
        rst = 1'b1;

        // Directed ALU cases
        issue(4'd0,  32'hFFFFFFFF, 32'd1, 32'h11, 32'd0, 2'd0, 5'd3, 3'b001);
        issue(4'd2,  32'd5, 32'd7, 32'h22, 32'd0, 2'd0, 5'd4, 3'b001);
        issue(4'd10, 32'h80000000, 32'd4, 32'h33, 32'd0, 2'd0, 5'd5, 3'b001);
        issue(4'd11, 32'h80000000, 32'd4, 32'h44, 32'd0, 2'd0, 5'd6, 3'b011);

        // Branches
        issue(4'd0, 32'd0, 32'd3, 32'd9, 32'h100, 2'd1, 5'd0, 3'b000);
        issue(4'd0, 32'h55, 32'd1, 32'h55, 32'h200, 2'd2, 5'd0, 3'b000);
        issue(4'd0, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 2'd3, 5'd0, 3'b000);

        // Multiply, including back-to-back
        issue(4'd12, 32'h00012345, 32'h00000100, 32'hAA, 32'd0, 2'd0, 5'd7, 3'b001);
        issue(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hBB, 32'd0, 2'd0, 5'd8, 3'b001);
        issue(4'd12, 32'd3, 32'd4, 32'hCC, 32'd0, 2'd0, 5'd9, 3'b001);
        issue(4'd12, 32'd5, 32'd6, 32'hDD, 32'd0, 2'd0, 5'd10, 3'b001);
        issue(4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 2'd0, 5'd11, 3'b001);

        // Reset during BUSY iteration 10
        @(negedge clk);
        drive(4'd12, 32'd77, 32'd99, 32'hEE, 32'd0, 2'd0, 5'd12, 3'b001);
        #1;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check("freeze_pre_rst", {31'd0, Freeze}, 32'd1);
            push_bubble();
        end
        @(negedge clk);
        rst = 1'b0;
        drive(4'd0, 0, 0, 0, 0, 2'd0, 5'd0, 3'd0);
        #1;
        check_all_zero("midrst");
        check("midrst_freeze", {31'd0, Freeze}, 32'd0);
        last_res = '0;
        last_st = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(4'd12, 32'd2, 32'd2, 32'h5, 32'd0, 2'd0, 5'd13, 3'b001);

        // Randomized ALU/branch traffic with occasional multiplies
        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(0, 15));
            if (c == 4'd12) c = 4'd0;
            a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            b = $urandom;
            r = ($urandom_range(0, 2) == 0) ? a : $urandom;
            issue(c, a, b, r, $urandom, 2'($urandom), 5'($urandom), 3'($urandom));
        end
        for (int i = 0; i < 3; i++) begin
            issue(4'd12, $urandom, $urandom, $urandom, 32'd0, 2'd0, 5'($urandom), 3'($urandom));
        end
        issue(4'd5, 32'h0F0F0000, 32'h0000F0F0, 32'h1, 32'd0, 2'd0, 5'd1, 3'b101);

        @(posedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage MIPS pipeline: consumes the ID/EX register outputs, performs ALU operations and a multi-cycle 32-iteration shift-add multiply, resolves branches, and registers its results into the EXE/MEM boundary. Produces `Br_taken`, which drives the IF/ID and ID/EX `Flush` inputs, and `Br_Addr`. Produces `Freeze`, which stalls the PC and the IF/ID and ID/EX registers while a multiply is in progress.

## Interface
- No parameters; widths are fixed by the 32-bit datapath.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `Dest_in`  in  5  destination register from ID/EX.
- `Reg2_in`  in  32  second register-file operand, used as store data and as the BNE comparand.
- `Val1_in`  in  32  first ALU operand.
- `Val2_in`  in  32  second ALU operand, either an immediate or a register value.
- `PC_in`  in  32  PC+4 of this instruction.
- `br_type_in`  in  2  branch type: 00 none, 01 BEZ, 10 BNE, 11 JMP.
- `EXE_CMD_in`  in  4  operation select.
- `MEM_R_EN_in`, `MEM_W_EN_in`, `WB_EN_in`  in  1 each  control bits passed through to EXE/MEM.
- `ALU_result`  out  32  registered result.
- `ST_val`  out  32  registered copy of `Reg2_in`.
- `Dest`  out  5  registered destination register.
- `MEM_R_EN`, `MEM_W_EN`, `WB_EN`  out  1 each  registered control bits.
- `Br_taken`  out  1  combinational branch-resolution flag.
- `Br_Addr`  out  32  combinational branch target.
- `Freeze`  out  1  combinational stall request to upstream stages.

## Operation
- **EXE_CMD encoding:**
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLA and 1001 SLL: `Val1 << Val2[4:0]`.
  - 1010 SRA: arithmetic right shift by `Val2[4:0]`.
  - 1011 SRL: logical right shift by `Val2[4:0]`.
  - 1100 MUL: low 32 bits of `Val1*Val2`.
  - All other codes produce a result of 0.
- **Arithmetic:** ADD and SUB are 32-bit modular; carry and overflow are discarded.
- **Multiply FSM states:**
  - IDLE: default state. If `EXE_CMD_in`=MUL, load the multiplicand from `Val1_in` and the multiplier from `Val2_in`, clear the accumulator and counter, and go to BUSY.
  - BUSY: each cycle, if `mplier[0]`, then `acc += mcand`. Then `mcand <<= 1` and `mplier >>= 1`, and the counter increments. When the counter reaches 31 (the 32nd iteration), go to DONE.
  - DONE: `acc` is driven to the output mux. Return to IDLE on the next edge.
- **Freeze:** `Freeze = (IDLE && EXE_CMD_in==MUL) || BUSY`. Upstream holds all `*_in` signals stable while `Freeze` is high.
- **Output register update:**
  - While `Freeze`=1, the EXE/MEM outputs load a bubble: `MEM_R_EN`=`MEM_W_EN`=`WB_EN`=0 and `Dest`=0. `ALU_result` and `ST_val` hold their values.
  - Otherwise every output register loads from the inputs and the current result. In DONE the current result is `acc`; in IDLE it is the combinational ALU result.
- **Branch resolution:**
  - The branch condition is: BEZ when `Val1_in`==0, BNE when `Val1_in`!=`Reg2_in`, JMP always.
  - `Br_taken` = condition && state==IDLE && !`Freeze`.
  - `Br_Addr = PC_in + (Val2_in << 2)`, 32-bit wrap.
  - A branch instruction still writes its EXE/MEM registers. Its control bits come from decode, normally 0.
- **Reset:** asynchronous, entered on `rst`=0.
  - All registered outputs go to 0, the FSM goes to IDLE, and `acc`, `mcand`, `mplier` and the counter go to 0.
  - A multiply in progress is abandoned.
  - After release, `Freeze` may assert immediately if `EXE_CMD_in`=MUL.

## Timing
- **Non-MUL latency:** an instruction presented in cycle N appears on the outputs after the edge ending cycle N.
- **MUL, presented in cycle N (state IDLE):**
  - `Freeze` is high in cycles N through N+32: one detect cycle plus 32 BUSY cycles.
  - Cycle N+33 is the DONE cycle, with `Freeze` low.
  - The product and its control bits appear after the edge ending cycle N+33.
  - Upstream advances at that same edge.
  - The EXE/MEM outputs show bubbles after the edges ending cycles N through N+32.
- **Back-to-back MUL:** a MUL arriving in the cycle after DONE starts a new detect cycle. DONE never restarts the FSM, even though `EXE_CMD_in` still reads MUL.
- **Combinational outputs:** `Br_taken`, `Br_Addr` and `Freeze` settle within the same cycle as their inputs. There are no registered stages on these paths.

## Test plan
- **Reset:** hold `rst`=0 with random inputs, then release. All outputs read 0, `Freeze`=0, FSM in IDLE.
- **ALU:**
  - ADD 0xFFFFFFFF+1 gives 0.
  - SUB 5-7 gives 0xFFFFFFFE.
  - SRA 0x80000000 by 4 gives 0xF8000000.
  - SRL of the same gives 0x08000000.
  - Each result appears one edge later, with `WB_EN` passed through.
- **MUL:**
  - 0x00012345 × 0x00000100 gives 0x01234500.
  - 0xFFFFFFFF × 0xFFFFFFFF gives 0x00000001.
  - Check `Freeze` is high for exactly 33 cycles and `WB_EN` reads 0 during them.
  - Check the result is output after cycle N+33.
- **Back-to-back MUL:** 3×4 then 5×6 yields 12 then 30. Each has its own 33-cycle freeze and there is no double-issue.
- **Branches:**
  - BEZ with `Val1`=0, `PC_in`=0x100 and `Val2`=3 gives `Br_taken`=1 and `Br_Addr`=0x10C.
  - BNE with equal operands gives `Br_taken`=0.
  - JMP with `Val2`=0xFFFFFFFF and `PC_in`=0 gives `Br_Addr`=0xFFFFFFFC.
- **Reset mid-multiply:** assert `rst`=0 at BUSY iteration 10. Outputs clear asynchronously, the FSM returns to IDLE, and a fresh 2×2 afterwards gives 4 with a full 33-cycle freeze.
